ascon_linear_serial: RTL

Slice-serial ASCON linear diffusion layer that sits directly downstream of the bit-sliced substitution stage `ASCON_SBOX`. It collects the five 64-bit state words as WIDTH-bit slices, one slice per word per beat, and buffers a full 64-bit round. It then applies the five ASCON rotate-XOR diffusion functions to the buffered round and streams the result back out in the same slice order for the next round's constant addition and substitution.

---
 rtl/ascon_linear_serial.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ascon_linear_serial.sv
// -----------------------------------------------------------------------------
// ascon_linear_serial
//
// Slice-serial ASCON linear diffusion layer. It sits right after the
// bit-sliced substitution stage. Five 64-bit state words arrive as WIDTH-bit
// slices, least significant slice first. A full round is buffered, the five
// ASCON rotate-XOR functions are applied in one cycle, and the diffused words
// are streamed back out in the same slice order.
//
// Parameters
//   WIDTH        bits per word per beat (1, 2, 4 or 8); SLICES = 64/WIDTH
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   upstream slice valid
//   in_ready_o   block accepts a slice (FILL only)
//   x0_i..x4_i   incoming slice of state words 0..4
//   out_valid_o  diffused slice valid (DRAIN only)
//   out_ready_i  downstream accepts a slice
//   x0_o..x4_o   diffused slice of state words 0..4
//   busy_o       high while computing or draining
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid high keeps its data stable until the
// transfer; valid never depends on ready. Both ready and valid here are
// decoded from the state register only, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module ascon_linear_serial #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] x1_i,
  input  logic [WIDTH-1:0] x2_i,
  input  logic [WIDTH-1:0] x3_i,
  input  logic [WIDTH-1:0] x4_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] x0_o,
  output logic [WIDTH-1:0] x1_o,
  output logic [WIDTH-1:0] x2_o,
  output logic [WIDTH-1:0] x3_o,
  output logic [WIDTH-1:0] x4_o,
  output logic             busy_o
);

  localparam int SLICES = 64 / WIDTH;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   buf0;
  logic [63:0]   buf1;
  logic [63:0]   buf2;
  logic [63:0]   buf3;
  logic [63:0]   buf4;

  logic in_hs;
  logic out_hs;

  // Rotate right: bit i of the result is x[(i+n) mod 64].
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sigma(input logic [63:0] x,
                                        input int unsigned a,
                                        input int unsigned b);
    return x ^ ror(x, a) ^ ror(x, b);
  endfunction

  assign in_ready_o  = (state == FILL);
  assign out_valid_o = (state == DRAIN);
  assign busy_o      = (state == COMPUTE) || (state == DRAIN);

  assign in_hs  = in_valid_i  && (state == FILL);
  assign out_hs = out_ready_i && (state == DRAIN);

  // The output slice is always the low end of each buffer; the buffers only
  // move on a handshake, so the slice holds steady under backpressure.
  assign x0_o = buf0[WIDTH-1:0];
  assign x1_o = buf1[WIDTH-1:0];
  assign x2_o = buf2[WIDTH-1:0];
  assign x3_o = buf3[WIDTH-1:0];
  assign x4_o = buf4[WIDTH-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FILL;
      cnt   <= '0;
      buf0  <= '0;
      buf1  <= '0;
      buf2  <= '0;
      buf3  <= '0;
      buf4  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            // New slices enter at the top so that after SLICES beats the
            // first (least significant) slice has reached bit 0.
            buf0 <= {x0_i, buf0[63:WIDTH]};
            buf1 <= {x1_i, buf1[63:WIDTH]};
            buf2 <= {x2_i, buf2[63:WIDTH]};
            buf3 <= {x3_i, buf3[63:WIDTH]};
            buf4 <= {x4_i, buf4[63:WIDTH]};
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= COMPUTE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        COMPUTE: begin
          buf0  <= sigma(buf0, 19, 28);
          buf1  <= sigma(buf1, 61, 39);
          buf2  <= sigma(buf2, 1, 6);
          buf3  <= sigma(buf3, 10, 17);
          buf4  <= sigma(buf4, 7, 41);
          state <= DRAIN;
        end

        DRAIN: begin
          if (out_hs) begin
            buf0 <= buf0 >> WIDTH;
            buf1 <= buf1 >> WIDTH;
            buf2 <= buf2 >> WIDTH;
            buf3 <= buf3 >> WIDTH;
            buf4 <= buf4 >> WIDTH;
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
